// File: rtl/cochlea_chan_ctrl.sv
// cochlea_chan_ctrl: per-channel phase-clock generation, mixer LO select,
// comparator feedback capture and windowed event counting with a
// valid/ready readout of per-channel counts for an N-channel analog core.
module cochlea_chan_ctrl #(
    parameter int NCH   = 8,
    parameter int DIV_W = 8,
    parameter int CNT_W = 12,
    parameter int WIN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NCH*DIV_W-1:0]   div_cfg,
    input  logic [1:0]             lo_mode,
    input  logic [WIN_W-1:0]       win_len,
    input  logic [NCH-1:0]         high_buf,
    input  logic [NCH-1:0]         phi1b_dig,
    output logic [NCH-1:0]         cclk,
    output logic [NCH-1:0]         div2,
    output logic [NCH-1:0]         lo,
    output logic [NCH-1:0]         fb1,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(NCH)-1:0] rd_chan,
    output logic [CNT_W-1:0]       rd_count,
    output logic                   rd_sat,
    output logic                   overrun
);

    localparam int              IDX_W    = $clog2(NCH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             overrun_q, overrun_d;

    // Two-flop synchronisers; ph_s3_q keeps the previous synced phi value
    logic [NCH-1:0] hb_s1_q, hb_s2_q;
    logic [NCH-1:0] ph_s1_q, ph_s2_q, ph_s3_q;
    logic [NCH-1:0] ph_rise;

    logic win_term;
    logic snap_take;

    // Shadow counts of all channels, flattened so the readout can index them
    logic [NCH*CNT_W-1:0] shadow_flat;

    assign ph_rise   = ph_s2_q & ~ph_s3_q;
    assign win_term  = en && (win_cnt_q >= win_len);
    // A window end only lands in the shadows when the readout is idle
    assign snap_take = win_term && (state_q == ST_IDLE);

    // Synchronise the asynchronous comparator and event-clock inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_s1_q <= '0;
            hb_s2_q <= '0;
            ph_s1_q <= '0;
            ph_s2_q <= '0;
            ph_s3_q <= '0;
        end else begin
            hb_s1_q <= high_buf;
            hb_s2_q <= hb_s1_q;
            ph_s1_q <= phi1b_dig;
            ph_s2_q <= ph_s1_q;
            ph_s3_q <= ph_s2_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
            logic             cclk_q, cclk_d;
            logic             div2_q, div2_d;
            logic             lo_q, lo_d;
            logic             fb1_q, fb1_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] shadow_q, shadow_d;
            logic [CNT_W-1:0] cnt_sum;
            logic             inc;

            // An event counts only when the captured comparator sample is high
            assign inc     = en & ph_rise[gi] & hb_s2_q[gi];
            assign cnt_sum = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(inc);

            // Per-channel divider, feedback capture, live count and shadow update
            always_comb begin
                div_cnt_d = div_cnt_q;
                cclk_d    = cclk_q;
                div2_d    = div2_q;
                fb1_d     = fb1_q;
                cnt_d     = cnt_q;
                shadow_d  = shadow_q;
                if (!en) begin
                    div_cnt_d = '0;
                    cclk_d    = 1'b0;
                    div2_d    = 1'b0;
                    cnt_d     = '0;
                end else begin
                    if (div_cnt_q >= div_cfg[gi*DIV_W +: DIV_W]) begin
                        div_cnt_d = '0;
                        cclk_d    = ~cclk_q;
                        // div2 advances on every cclk rising transition
                        if (!cclk_q) begin
                            div2_d = ~div2_q;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                    if (ph_rise[gi]) begin
                        fb1_d = hb_s2_q[gi];
                    end
                    if (win_term) begin
                        cnt_d = '0;
                        if (snap_take) begin
                            shadow_d = cnt_sum;
                        end
                    end else begin
                        cnt_d = cnt_sum;
                    end
                end
            end

            // LO source select from the registered phase clocks
            always_comb begin
                case (lo_mode)
                    2'd0:    lo_d = 1'b0;
                    2'd1:    lo_d = cclk_q;
                    2'd2:    lo_d = div2_q;
                    default: lo_d = ~div2_q;
                endcase
            end

            // Per-channel state registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div_cnt_q <= '0;
                    cclk_q    <= 1'b0;
                    div2_q    <= 1'b0;
                    lo_q      <= 1'b0;
                    fb1_q     <= 1'b0;
                    cnt_q     <= '0;
                    shadow_q  <= '0;
                end else begin
                    div_cnt_q <= div_cnt_d;
                    cclk_q    <= cclk_d;
                    div2_q    <= div2_d;
                    lo_q      <= lo_d;
                    fb1_q     <= fb1_d;
                    cnt_q     <= cnt_d;
                    shadow_q  <= shadow_d;
                end
            end

            assign cclk[gi] = cclk_q;
            assign div2[gi] = div2_q;
            assign lo[gi]   = lo_q;
            assign fb1[gi]  = fb1_q;
            assign shadow_flat[gi*CNT_W +: CNT_W] = shadow_q;
        end
    endgenerate

    // Window counter, readout FSM and sticky overrun registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            win_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            win_cnt_q <= win_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state: window wrap, readout sequencing, overrun on a busy window end
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        win_cnt_d = win_cnt_q;
        overrun_d = overrun_q;
        if (!en) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            win_cnt_d = '0;
            overrun_d = 1'b0;
        end else begin
            win_cnt_d = win_term ? '0 : win_cnt_q + WIN_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (win_term) begin
                        state_d = ST_SEND;
                        idx_d   = '0;
                    end
                end
                default: begin
                    if (rd_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    // Includes a window end coinciding with the final accept
                    if (win_term) begin
                        overrun_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Readout outputs, driven to zero while idle
    always_comb begin
        rd_valid = 1'b0;
        rd_chan  = '0;
        rd_count = '0;
        rd_sat   = 1'b0;
        if (state_q == ST_SEND) begin
            rd_valid = 1'b1;
            rd_chan  = idx_q;
            rd_count = shadow_flat[idx_q*CNT_W +: CNT_W];
            rd_sat   = &shadow_flat[idx_q*CNT_W +: CNT_W];
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_cochlea_chan_ctrl.sv
// Self-checking bench for cochlea_chan_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model built from
// closed-form divider arithmetic and a readout word queue.
module tb_cochlea_chan_ctrl;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;
    localparam int CNT_W = 4;
    localparam int WIN_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en = 1'b0;
    logic [NCH*DIV_W-1:0]   div_cfg = '0;
    logic [1:0]             lo_mode = 2'd0;
    logic [WIN_W-1:0]       win_len = '0;
    logic [NCH-1:0]         high_buf = '0;
    logic [NCH-1:0]         phi1b_dig = '0;
    logic                   rd_ready = 1'b0;
    logic [NCH-1:0]         cclk, div2, lo, fb1;
    logic                   rd_valid;
    logic [$clog2(NCH)-1:0] rd_chan;
    logic [CNT_W-1:0]       rd_count;
    logic                   rd_sat;
    logic                   overrun;

    cochlea_chan_ctrl #(
        .NCH  (NCH),
        .DIV_W(DIV_W),
        .CNT_W(CNT_W),
        .WIN_W(WIN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_cfg  (div_cfg),
        .lo_mode  (lo_mode),
        .win_len  (win_len),
        .high_buf (high_buf),
        .phi1b_dig(phi1b_dig),
        .cclk     (cclk),
        .div2     (div2),
        .lo       (lo),
        .fb1      (fb1),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_chan  (rd_chan),
        .rd_count (rd_count),
        .rd_sat   (rd_sat),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Configuration as the bench applied it
    int dcfg[NCH];
    int wlen;

    // Behavioural model
    typedef struct {
        int chan;
        int cnt;
    } word_t;
    int             m_k;
    int             m_cclk[NCH], m_div2[NCH], m_lo[NCH], m_fb1[NCH], m_cnt[NCH];
    int             m_ovr;
    word_t          m_q[$];
    logic [NCH-1:0] ph_h[3], hb_h[3];

    // Words seen leaving the DUT
    int seen_cnt[NCH];
    int seen_sat[NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NCH; i++) div_cfg[i*DIV_W +: DIV_W] = DIV_W'(dcfg[i]);
        win_len = WIN_W'(wlen);
    endtask

    task automatic model_reset();
        m_k = 0;
        m_ovr = 0;
        m_q.delete();
        for (int i = 0; i < NCH; i++) begin
            m_cclk[i] = 0; m_div2[i] = 0; m_lo[i] = 0; m_fb1[i] = 0; m_cnt[i] = 0;
        end
        for (int j = 0; j < 3; j++) begin
            ph_h[j] = '0; hb_h[j] = '0;
        end
    endtask

    function automatic int lo_of(input int mode, input int c, input int d);
        case (mode)
            0:       return 0;
            1:       return c;
            2:       return d;
            default: return 1 - d;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        logic [NCH-1:0] rise, hbs;
        bit    accept, term, was_empty;
        int    t, sum;
        int    nlo[NCH];
        int    snap[NCH];
        word_t w;
        if (!rst_n) return;
        for (int i = 0; i < NCH; i++) nlo[i] = lo_of(int'(lo_mode), m_cclk[i], m_div2[i]);
        // Event seen two edges after the sample, rising against the one before
        rise      = ph_h[1] & ~ph_h[2];
        hbs       = hb_h[1];
        was_empty = (m_q.size() == 0);
        accept    = !was_empty && rd_ready;
        if (!en) begin
            m_k = 0;
            m_ovr = 0;
            m_q.delete();
            for (int i = 0; i < NCH; i++) begin
                m_cclk[i] = 0; m_div2[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            m_k++;
            term = ((m_k % (wlen + 1)) == 0);
            if (term && !was_empty) m_ovr = 1;
            for (int i = 0; i < NCH; i++) begin
                t = m_k / (dcfg[i] + 1);
                m_cclk[i] = t % 2;
                m_div2[i] = ((t + 1) / 2) % 2;
                if (rise[i]) m_fb1[i] = int'(hbs[i]);
                sum = m_cnt[i] + ((rise[i] && hbs[i]) ? 1 : 0);
                if (sum > CMAX) sum = CMAX;
                snap[i]  = sum;
                m_cnt[i] = term ? 0 : sum;
            end
            if (accept) void'(m_q.pop_front());
            if (term && was_empty) begin
                for (int i = 0; i < NCH; i++) begin
                    w.chan = i;
                    w.cnt  = snap[i];
                    m_q.push_back(w);
                end
            end
        end
        for (int i = 0; i < NCH; i++) m_lo[i] = nlo[i];
        ph_h[2] = ph_h[1]; ph_h[1] = ph_h[0]; ph_h[0] = phi1b_dig;
        hb_h[2] = hb_h[1]; hb_h[1] = hb_h[0]; hb_h[0] = high_buf;
    endtask

    task automatic check_all();
        logic [NCH-1:0] e_c, e_d, e_l, e_f;
        for (int i = 0; i < NCH; i++) begin
            e_c[i] = m_cclk[i][0]; e_d[i] = m_div2[i][0];
            e_l[i] = m_lo[i][0];   e_f[i] = m_fb1[i][0];
        end
        chk("cclk", 32'(cclk), 32'(e_c));
        chk("div2", 32'(div2), 32'(e_d));
        chk("lo", 32'(lo), 32'(e_l));
        chk("fb1", 32'(fb1), 32'(e_f));
        chk("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_q.size() > 0) begin
            chk("rd_chan", 32'(rd_chan), 32'(m_q[0].chan));
            chk("rd_count", 32'(rd_count), 32'(m_q[0].cnt));
            chk("rd_sat", 32'(rd_sat), 32'(m_q[0].cnt == CMAX));
        end
    endtask

    task automatic step();
        if (rd_valid && rd_ready) begin
            seen_cnt[rd_chan] = int'(rd_count);
            seen_sat[rd_chan] = int'(rd_sat);
            $display("word chan=%0d count=%0d sat=%0d t=%0t", rd_chan, rd_count, rd_sat, $time);
        end
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic rand_inputs();
        phi1b_dig = NCH'($urandom);
        high_buf  = NCH'($urandom);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int n = 0; n < budget && !rd_valid; n++) begin
            rand_inputs();
            step();
        end
        chk(tag, 32'(rd_valid), 32'd1);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < NCH; i++) begin
            seen_cnt[i] = -1; seen_sat[i] = -1;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_cclk"}, 32'(cclk), 32'd0);
        chk({tag, "_div2"}, 32'(div2), 32'd0);
        chk({tag, "_lo"}, 32'(lo), 32'd0);
        chk({tag, "_fb1"}, 32'(fb1), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_chan"}, 32'(rd_chan), 32'd0);
        chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        chk({tag, "_rd_sat"}, 32'(rd_sat), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        model_reset();
        clear_seen();
        for (int i = 0; i < NCH; i++) dcfg[i] = 0;
        wlen = 999;
        apply_cfg();

        // Reset state
        @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        steps(3);

        // Divider: ch0 D=0, ch1 D=3, lo = ~div2 one cycle late
        dcfg[0] = 0; dcfg[1] = 3; dcfg[2] = 1; dcfg[3] = 5;
        apply_cfg();
        lo_mode = 2'd3;
        en = 1'b1;
        steps(3);
        chk("ch1_before_rise", 32'(cclk[1]), 32'd0);
        step();
        chk("ch1_first_rise", 32'(cclk[1]), 32'd1);
        steps(40);

        // Feedback: three 4-cycle pulses on ch2 with high_buf[2] held high
        en = 1'b0;
        step();
        wlen = 99;
        apply_cfg();
        high_buf = 4'b0100;
        phi1b_dig = '0;
        rd_ready = 1'b1;
        en = 1'b1;
        clear_seen();
        for (int p = 0; p < 3; p++) begin
            phi1b_dig[2] = 1'b1;
            steps(4);
            phi1b_dig[2] = 1'b0;
            steps(4);
        end
        chk("fb1_ch2_set", 32'(fb1[2]), 32'd1);
        for (int n = 0; n < 150 && !rd_valid; n++) step();
        chk("fb_wait_valid", 32'(rd_valid), 32'd1);
        steps(NCH + 1);
        chk("fb_word2", 32'(seen_cnt[2]), 32'd3);
        chk("fb_word0", 32'(seen_cnt[0]), 32'd0);
        chk("fb_word3", 32'(seen_cnt[3]), 32'd0);
        chk("fb_done", 32'(rd_valid), 32'd0);

        // Saturation: 20 events on ch1 in one window
        en = 1'b0;
        step();
        wlen = 199;
        apply_cfg();
        high_buf = 4'b0010;
        en = 1'b1;
        clear_seen();
        for (int p = 0; p < 20; p++) begin
            phi1b_dig[1] = 1'b1;
            steps(2);
            phi1b_dig[1] = 1'b0;
            steps(2);
        end
        for (int n = 0; n < 200 && !rd_valid; n++) step();
        chk("sat_wait_valid", 32'(rd_valid), 32'd1);
        steps(NCH + 1);
        chk("sat_count", 32'(seen_cnt[1]), 32'(CMAX));
        chk("sat_flag", 32'(seen_sat[1]), 32'd1);

        // Backpressure: word 0 held for 10 cycles, then NCH words in order
        en = 1'b0;
        step();
        wlen = 49;
        apply_cfg();
        rd_ready = 1'b0;
        en = 1'b1;
        wait_valid("bp_wait_valid", 100);
        for (int n = 0; n < 10; n++) begin
            rand_inputs();
            step();
            chk("bp_hold_valid", 32'(rd_valid), 32'd1);
            chk("bp_hold_chan", 32'(rd_chan), 32'd0);
        end
        rd_ready = 1'b1;
        steps(NCH);
        chk("bp_done", 32'(rd_valid), 32'd0);

        // Overrun: short windows with no consumer
        en = 1'b0;
        step();
        wlen = 3;
        apply_cfg();
        rd_ready = 1'b0;
        en = 1'b1;
        for (int n = 0; n < 7; n++) begin
            rand_inputs();
            step();
        end
        chk("ovr_before", 32'(overrun), 32'd0);
        step();
        chk("ovr_after_second_term", 32'(overrun), 32'd1);
        for (int n = 0; n < 5; n++) begin
            rand_inputs();
            step();
        end
        en = 1'b0;
        step();
        chk("ovr_cleared_by_en", 32'(overrun), 32'd0);

        // Randomised rounds
        for (int r = 0; r < 6; r++) begin
            en = 1'b0;
            step();
            for (int i = 0; i < NCH; i++) dcfg[i] = int'($urandom_range(0, 5));
            wlen = int'($urandom_range(3, 24));
            apply_cfg();
            lo_mode = 2'($urandom);
            en = 1'b1;
            for (int n = 0; n < 200; n++) begin
                rand_inputs();
                rd_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) lo_mode = 2'($urandom);
                step();
            end
        end

        // Asynchronous reset in the middle of a readout
        en = 1'b0;
        step();
        wlen = 9;
        apply_cfg();
        rd_ready = 1'b0;
        en = 1'b1;
        wait_valid("rst_wait_valid", 50);
        steps(2);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        for (int n = 0; n < 2; n++) begin
            rand_inputs();
            step();
        end
        rst_n = 1'b1;
        rd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rand_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cochlea_chan_ctrl.md
# cochlea_chan_ctrl

Parametrised digital controller for an N-channel cochlea analog core. It generates per-channel phase clocks (`cclk`, `div2`) and mixer LO, and closes the comparator feedback loop (`high_buf` sampled on `phi1b_dig` rising edges into `fb1`). It also counts comparator-high decisions over a programmable window and streams per-channel counts out through a valid/ready port. It sits between the Wishbone/config logic and the analog core macro, replacing fixed 8-channel direct wiring.

## Interface
Parameters:
- `NCH`, 8, number of analog channels (≥2)
- `DIV_W`, 8, divider config width per channel
- `CNT_W`, 12, event counter width
- `WIN_W`, 16, window length width

Ports:
- `clk` in 1, single system clock
- `rst_n` in 1, asynchronous active-low reset
- `en` in 1, global enable
- `div_cfg` in NCH*DIV_W, channel i at `[i*DIV_W +: DIV_W]`, cclk half-period minus 1, in clk cycles
- `lo_mode` in 2, LO source select (0: 0, 1: cclk, 2: div2, 3: ~div2)
- `win_len` in WIN_W, window length minus 1, in clk cycles
- `high_buf` in NCH, comparator outputs from core (asynchronous)
- `phi1b_dig` in NCH, event clocks from core (asynchronous)
- `cclk`, `div2`, `lo`, `fb1` out NCH, to core
- `rd_valid` out 1, readout word valid
- `rd_ready` in 1, consumer accept
- `rd_chan` out $clog2(NCH), channel index of current word
- `rd_count` out CNT_W, count for `rd_chan`
- `rd_sat` out 1, `rd_count` is saturated (all ones)
- `overrun` out 1, sticky: a window ended before the previous readout finished

## Operation
- Reset: every output, counter, synchroniser, shadow register and the FSM go to 0/IDLE.
- `en`=0 (synchronous): dividers, `cclk`, `div2`, window counter, live counts, `overrun`, FSM (→IDLE) are cleared; `fb1` and shadow registers hold.
- Divider, per channel: counter increments each cycle. When counter ≥ `div_cfg[i]`, counter←0 and `cclk[i]` toggles. `div2[i]` toggles in the same cycle that `cclk[i]` goes 0→1. A config change applies at the next compare.
- `lo[i]` is registered and follows `lo_mode` from the registered `cclk`/`div2` values. It lags them by one cycle.
- Synchronisers: 2-flop on each bit of `high_buf` and `phi1b_dig`. A rising edge is sync stage 2 high while the previous value was low.
- On a rising edge of channel i: `fb1[i]` ← synced `high_buf[i]`. If that sample is 1, live `cnt[i]` increments, saturating at 2^CNT_W−1.
- Window: counter counts 0..`win_len`. In the terminal cycle, `shadow[i]` ← saturating `cnt[i]` plus that cycle's increment, and `cnt[i]` ← 0 for all i. If the FSM is not IDLE, the snapshot is dropped (shadow unchanged), `overrun` ← 1, and live counts still clear.
- Readout FSM:
  - IDLE→SEND on a snapshot, with idx=0.
  - In SEND: `rd_valid`=1, `rd_chan`=idx, `rd_count`=`shadow[idx]`, `rd_sat`=(`shadow[idx]` all ones). Outputs stay stable until accepted.
  - On `rd_valid`&`rd_ready`: idx increments. Acceptance at idx=NCH−1 → IDLE, so `rd_valid` is 0 the next cycle.
  - A snapshot arriving in the cycle of the final accept counts as overrun.

## Timing
- `phi1b_dig`/`high_buf` stable before clk edge E → `fb1` and count updated at edge E+2, visible after E+2.
- `cclk` period 2(D+1) clk and `div2` period 4(D+1) clk, for D=`div_cfg[i]`. First `cclk` rise is D+1 cycles after `en` rises.
- Window period `win_len`+1 cycles. `rd_valid` rises the cycle after the terminal cycle.
- With `rd_ready` held high, the full readout takes NCH cycles.
- Pulses on `phi1b_dig` shorter than 2 clk periods are not guaranteed to be detected.

## Test plan
- Divider: `div_cfg` ch0=0, ch1=3, `en`=1 → ch0 cclk period 2 and div2 period 4; ch1 cclk period 8 and div2 period 16. `lo_mode`=3 → `lo` = ~div2, delayed 1 cycle.
- Feedback: hold `high_buf[2]`=1 and pulse `phi1b_dig[2]` 3 times (4-cycle pulses), `win_len`=99 → `fb1[2]`=1 two edges after the first pulse. Readout word idx 2 = 3; all other channels 0.
- Saturation: CNT_W=4, 20 high events in one window → `rd_count`=15, `rd_sat`=1.
- Backpressure: `rd_ready` low for 10 cycles, then high → word 0 held stable, then NCH words in order, then `rd_valid`=0.
- Overrun: `win_len`=3, `rd_ready`=0 → `overrun`=1 after the second terminal cycle. Shadow keeps the first window; `en`=0 clears `overrun`.
- Async reset: assert `rst_n` mid-readout → all outputs 0 immediately. After release, normal first window behaviour.
